// File: rtl/reg_file_alu_pkg.sv
// Shared types and constants for the reg_file_alu control sequencer.
// Holds the instruction field layout, opcodes, ALU selects, FSM states and control bundle.
package reg_file_alu_pkg;

  localparam int unsigned PC_W    = 8;
  localparam int unsigned INSTR_W = 16;
  localparam int unsigned REG_AW  = 4;
  localparam int unsigned IMM_W   = 8;
  localparam int unsigned RET_W   = 8;

  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned A_MSB   = 11;
  localparam int unsigned A_LSB   = 8;
  localparam int unsigned B_MSB   = 7;
  localparam int unsigned B_LSB   = 4;
  localparam int unsigned C_MSB   = 3;
  localparam int unsigned C_LSB   = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_ADDI = 4'h5,
    OP_LI   = 4'h6,
    OP_BEQZ = 4'h7,
    OP_JMP  = 4'h8,
    OP_HALT = 4'hF
  } opcode_t;

  typedef enum logic [1:0] {
    ALU_AND = 2'b00,
    ALU_OR  = 2'b01,
    ALU_ADD = 2'b10,
    ALU_SUB = 2'b11
  } alu_ctrl_t;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_FETCH  = 3'd1;
  localparam state_t S_DECODE = 3'd2;
  localparam state_t S_EXEC   = 3'd3;
  localparam state_t S_HALT   = 3'd4;

  typedef struct packed {
    logic [REG_AW-1:0] ra1;
    logic [REG_AW-1:0] ra2;
    logic [REG_AW-1:0] wa;
    logic              we;
    logic              alu_src;
    alu_ctrl_t         alu_ctrl;
    logic [IMM_W-1:0]  imm;
  } ctrl_t;

  // Register-register ALU op; writes to x0 are suppressed but WA is still driven.
  function automatic ctrl_t rtype_ctrl(input logic [REG_AW-1:0] rd,
                                       input logic [REG_AW-1:0] rs1,
                                       input logic [REG_AW-1:0] rs2,
                                       input alu_ctrl_t fn);
    ctrl_t c;
    c          = '0;
    c.wa       = rd;
    c.ra1      = rs1;
    c.ra2      = rs2;
    c.we       = (rd != '0);
    c.alu_ctrl = fn;
    return c;
  endfunction

endpackage

// File: rtl/reg_file_alu_ctrl_if.sv
// Instruction ROM port, datapath control and start/done handshake of the sequencer.
interface reg_file_alu_ctrl_if;
  import reg_file_alu_pkg::*;

  logic               start;
  logic               done;
  logic               illegal;
  logic [PC_W-1:0]    instr_addr;
  logic [INSTR_W-1:0] instr_rdata;
  logic [REG_AW-1:0]  RA1;
  logic [REG_AW-1:0]  RA2;
  logic [REG_AW-1:0]  WA;
  logic               write_enable;
  logic               ALUSrc;
  logic [1:0]         ALUControl;
  logic [IMM_W-1:0]   immediate;
  logic               Zero;
  logic [RET_W-1:0]   retired;

  modport master (
    input  start, instr_rdata, Zero,
    output done, illegal, instr_addr, RA1, RA2, WA, write_enable,
           ALUSrc, ALUControl, immediate, retired
  );

  modport slave (
    output start, instr_rdata, Zero,
    input  done, illegal, instr_addr, RA1, RA2, WA, write_enable,
           ALUSrc, ALUControl, immediate, retired
  );

endinterface

// File: rtl/reg_file_alu_decode.sv
// Combinational instruction decoder: instruction word to datapath control bundle and flow flags.
module reg_file_alu_decode
  import reg_file_alu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output logic [PC_W-1:0]    target,
  output logic               is_branch,
  output logic               is_jump,
  output logic               is_halt,
  output logic               is_illegal
);

  logic [3:0]        op;
  logic [REG_AW-1:0] fa;
  logic [REG_AW-1:0] fb;
  logic [REG_AW-1:0] fc;
  logic [IMM_W-1:0]  imm8;

  assign op     = instr[OP_MSB:OP_LSB];
  assign fa     = instr[A_MSB:A_LSB];
  assign fb     = instr[B_MSB:B_LSB];
  assign fc     = instr[C_MSB:C_LSB];
  assign imm8   = instr[IMM_MSB:IMM_LSB];
  assign target = PC_W'(imm8);

  always_comb begin
    ctrl       = '0;
    is_branch  = 1'b0;
    is_jump    = 1'b0;
    is_halt    = 1'b0;
    is_illegal = 1'b0;
    case (op)
      OP_NOP:  ;
      OP_ADD:  ctrl = rtype_ctrl(fa, fb, fc, ALU_ADD);
      OP_SUB:  ctrl = rtype_ctrl(fa, fb, fc, ALU_SUB);
      OP_AND:  ctrl = rtype_ctrl(fa, fb, fc, ALU_AND);
      OP_OR:   ctrl = rtype_ctrl(fa, fb, fc, ALU_OR);
      OP_ADDI: begin
        ctrl          = rtype_ctrl(fa, fa, '0, ALU_ADD);
        ctrl.alu_src  = 1'b1;
        ctrl.imm      = imm8;
      end
      OP_LI: begin
        ctrl          = rtype_ctrl(fa, '0, '0, ALU_ADD);
        ctrl.alu_src  = 1'b1;
        ctrl.imm      = imm8;
      end
      // Zero test: rs + 0 through the ALU, no write-back
      OP_BEQZ: begin
        ctrl.ra1      = fa;
        ctrl.alu_src  = 1'b1;
        ctrl.alu_ctrl = ALU_ADD;
        is_branch     = 1'b1;
      end
      OP_JMP:  is_jump    = 1'b1;
      OP_HALT: is_halt    = 1'b1;
      default: is_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/reg_file_alu_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC sequencer driving the reg_file_alu datapath from a synchronous ROM.
module reg_file_alu_ctrl
  import reg_file_alu_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST,
  reg_file_alu_ctrl_if.master  bus
);

  state_t            state, state_nxt;
  logic [PC_W-1:0]   pc, pc_nxt;
  logic [PC_W-1:0]   addr, addr_nxt;
  logic [RET_W-1:0]  retired, retired_nxt;
  ctrl_t             ctrl_q, ctrl_nxt;
  logic              done, done_nxt;
  logic              illegal, illegal_nxt;
  logic              br_q, br_nxt;
  logic              jmp_q, jmp_nxt;
  logic [PC_W-1:0]   tgt_q, tgt_nxt;

  ctrl_t             dec_ctrl;
  logic [PC_W-1:0]   dec_target;
  logic              dec_branch, dec_jump, dec_halt, dec_illegal;

  reg_file_alu_decode u_decode (
    .instr      (bus.instr_rdata),
    .ctrl       (dec_ctrl),
    .target     (dec_target),
    .is_branch  (dec_branch),
    .is_jump    (dec_jump),
    .is_halt    (dec_halt),
    .is_illegal (dec_illegal)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= S_IDLE;
      pc      <= '0;
      addr    <= '0;
      retired <= '0;
      ctrl_q  <= '0;
      done    <= 1'b0;
      illegal <= 1'b0;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      tgt_q   <= '0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      addr    <= addr_nxt;
      retired <= retired_nxt;
      ctrl_q  <= ctrl_nxt;
      done    <= done_nxt;
      illegal <= illegal_nxt;
      br_q    <= br_nxt;
      jmp_q   <= jmp_nxt;
      tgt_q   <= tgt_nxt;
    end
  end

  // Next state plus next values of every registered output; controls are zero outside EXEC.
  always_comb begin
    state_nxt   = state;
    pc_nxt      = pc;
    addr_nxt    = addr;
    retired_nxt = retired;
    ctrl_nxt    = '0;
    done_nxt    = done;
    illegal_nxt = illegal;
    br_nxt      = br_q;
    jmp_nxt     = jmp_q;
    tgt_nxt     = tgt_q;
    case (state)
      S_IDLE, S_HALT: begin
        if (bus.start) begin
          state_nxt   = S_FETCH;
          pc_nxt      = '0;
          addr_nxt    = '0;
          retired_nxt = '0;
          done_nxt    = 1'b0;
          illegal_nxt = 1'b0;
        end
      end
      S_FETCH: state_nxt = S_DECODE;
      S_DECODE: begin
        if (dec_halt || dec_illegal) begin
          state_nxt   = S_HALT;
          done_nxt    = 1'b1;
          illegal_nxt = dec_illegal;
        end else begin
          state_nxt = S_EXEC;
          ctrl_nxt  = dec_ctrl;
          br_nxt    = dec_branch;
          jmp_nxt   = dec_jump;
          tgt_nxt   = dec_target;
        end
      end
      S_EXEC: begin
        state_nxt   = S_FETCH;
        retired_nxt = retired + RET_W'(1);
        if (jmp_q || (br_q && bus.Zero)) pc_nxt = tgt_q;
        else                              pc_nxt = pc + PC_W'(1);
        addr_nxt    = pc_nxt;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign bus.instr_addr   = addr;
  assign bus.retired      = retired;
  assign bus.done         = done;
  assign bus.illegal      = illegal;
  assign bus.RA1          = ctrl_q.ra1;
  assign bus.RA2          = ctrl_q.ra2;
  assign bus.WA           = ctrl_q.wa;
  assign bus.write_enable = ctrl_q.we;
  assign bus.ALUSrc       = ctrl_q.alu_src;
  assign bus.ALUControl   = ctrl_q.alu_ctrl;
  assign bus.immediate    = ctrl_q.imm;

endmodule
